// File: rtl/da2_sample_feeder.sv
// da2_sample_feeder
// Upstream stage of the Pmod DA2 SPI master. A producer hands 12-bit
// samples over a valid/ready port into a small FIFO. A programmable rate
// counter produces one tick per sample period. On each tick the sequencer
// pops one sample, or resends the last one when the FIFO is empty. It
// formats the sample as {2'b00, pd_mode, sample} and starts one SPI
// transfer.
//
// Ports:
//   clk_i        system clock (same domain as the SPI master)
//   rst_i        synchronous active-high reset
//   enable_i     run pacing; 0 stops new transfers after the current one
//   rate_div_i   sample period = rate_div_i + 1 cycles (minimum 63)
//   pd_mode_i    DA2 power-down bits, captured into the word at LOAD
//   clr_flags_i  one-cycle pulse clearing underrun_o / overrun_o
//   s_valid_i    producer sample valid
//   s_data_i     producer sample
//   s_ready_o    FIFO can accept a sample
//   spi_start_o  one-cycle start pulse to the SPI master
//   spi_data_o   16-bit word to the SPI master's data_in
//   spi_busy_i   SPI master busy
//   fifo_level_o FIFO occupancy, 0..FIFO_DEPTH
//   underrun_o   sticky: a tick found the FIFO empty
//   overrun_o    sticky: a tick arrived while a transfer was in flight
module da2_sample_feeder #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic [15:0]        rate_div_i,
    input  logic [1:0]         pd_mode_i,
    input  logic               clr_flags_i,
    input  logic               s_valid_i,
    input  logic [11:0]        s_data_i,
    output logic               s_ready_o,
    output logic               spi_start_o,
    output logic [15:0]        spi_data_o,
    input  logic               spi_busy_i,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               underrun_o,
    output logic               overrun_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GUARD
    } state_t;

    localparam logic [FIFO_AW:0] FullLevel = (FIFO_AW + 1)'(FIFO_DEPTH);

    state_t               state_q;
    logic [11:0]          mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wrPtr_q, wrPtr_d;
    logic [FIFO_AW-1:0]   rdPtr_q, rdPtr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [15:0]          rateCnt_q, rateCnt_d;
    logic [11:0]          lastSample_q;
    logic [15:0]          spiData_q;
    logic                 spiStart_q;
    logic                 underrun_q;
    logic                 overrun_q;
    logic                 tick;
    logic                 push;
    logic                 pop;
    logic                 loadEmpty;
    logic [11:0]          head;

    assign s_ready_o    = (level_q < FullLevel);
    assign push         = s_valid_i && s_ready_o;
    // The pop condition uses the registered level, so a sample pushed into
    // an empty FIFO cannot be popped in the same cycle.
    assign pop          = (state_q == LOAD) && (level_q != '0);
    assign loadEmpty    = (state_q == LOAD) && (level_q == '0);
    assign head         = mem_q[rdPtr_q];
    assign tick         = enable_i && (rateCnt_q == rate_div_i);

    assign spi_start_o  = spiStart_q;
    assign spi_data_o   = spiData_q;
    assign fifo_level_o = level_q;
    assign underrun_o   = underrun_q;
    assign overrun_o    = overrun_q;

    // The pointers wrap for free because FIFO_DEPTH is a power of two.
    always_comb begin
        wrPtr_d   = wrPtr_q + FIFO_AW'(push);
        rdPtr_d   = rdPtr_q + FIFO_AW'(pop);
        level_d   = level_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        rateCnt_d = rateCnt_q + 16'd1;
        if (!enable_i || tick) begin
            rateCnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            level_q      <= '0;
            rateCnt_q    <= '0;
            lastSample_q <= '0;
            spiData_q    <= '0;
            spiStart_q   <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            rateCnt_q  <= rateCnt_d;
            spiStart_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        state_q <= LOAD;
                    end
                end
                // With an empty FIFO the previous sample is resent, which
                // holds the DAC output level steady.
                LOAD: begin
                    if (pop) begin
                        lastSample_q <= head;
                        spiData_q    <= {2'b00, pd_mode_i, head};
                    end else begin
                        spiData_q    <= {2'b00, pd_mode_i, lastSample_q};
                    end
                    spiStart_q <= 1'b1;
                    state_q    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (spi_busy_i) begin
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!spi_busy_i) begin
                        state_q <= GUARD;
                    end
                end
                // One spare cycle lets the master settle back to idle
                // before it can see another start.
                GUARD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // If a set event and a clear arrive together, the set wins.
            if (loadEmpty) begin
                underrun_q <= 1'b1;
            end else if (clr_flags_i) begin
                underrun_q <= 1'b0;
            end

            if (tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (clr_flags_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule
